// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Sequences JESD204 TPL DAC start-up: software sync pulse or external arm/trigger, then link settle.
// Latency: outputs registered, one cycle after the deciding edge; no backpressure, single-cycle requests.
// Backpressure: none; ctrl_start outside IDLE/RUNNING/ERROR is dropped, ctrl_abort always wins.
module ad_ip_jesd204_tpl_dac_sync_ctrl #(
    parameter int SYNC_PULSE_WIDTH = 4,
    parameter int SETTLE_CYCLES    = 16,
    parameter int TIMEOUT_WIDTH    = 16,
    parameter int CNT_WIDTH        = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ctrl_start,
    input  logic                     ctrl_abort,
    input  logic                     ctrl_ext_sync_en,
    input  logic [TIMEOUT_WIDTH-1:0] ctrl_timeout,
    input  logic                     sync_armed,
    input  logic                     link_ready,
    output logic                     dac_sync,
    output logic                     dac_ext_sync_arm,
    output logic                     dac_ext_sync_disarm,
    output logic                     status_busy,
    output logic                     status_running,
    output logic                     status_timeout,
    output logic [CNT_WIDTH-1:0]     status_sync_count
);

    localparam int PW = (SYNC_PULSE_WIDTH > 1) ? $clog2(SYNC_PULSE_WIDTH) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [PW-1:0] PULSE_LAST  = PW'(SYNC_PULSE_WIDTH - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_ARM,
        S_WAIT_ARMED,
        S_WAIT_TRIG,
        S_SETTLE,
        S_RUNNING,
        S_ERROR
    } state_t;

    state_t                   state, state_nxt;
    logic [PW-1:0]            pulse_cnt, pulse_cnt_nxt;
    logic [SW-1:0]            settle_cnt, settle_cnt_nxt;
    logic [TIMEOUT_WIDTH-1:0] to_cnt, to_cnt_nxt, to_inc;
    logic [CNT_WIDTH-1:0]     sync_count_nxt;
    logic                     disarm_nxt;
    logic                     timeout_nxt;
    logic                     start_ok;
    logic                     to_hit;
    logic                     waiting;

    assign waiting  = (state == S_WAIT_ARMED) || (state == S_WAIT_TRIG);
    assign start_ok = ctrl_start && !ctrl_abort &&
                      ((state == S_IDLE) || (state == S_RUNNING) || (state == S_ERROR));
    // Counter holds cycles spent waiting so far; the edge that completes ctrl_timeout cycles fires.
    assign to_inc   = to_cnt + 1'b1;
    assign to_hit   = (ctrl_timeout != '0) && (to_inc == ctrl_timeout);

    always_comb begin
        state_nxt      = state;
        pulse_cnt_nxt  = '0;
        settle_cnt_nxt = '0;
        to_cnt_nxt     = to_cnt;
        sync_count_nxt = status_sync_count;
        disarm_nxt     = 1'b0;
        timeout_nxt    = status_timeout;

        if (ctrl_abort && (state != S_IDLE)) begin
            state_nxt  = S_IDLE;
            disarm_nxt = waiting;
        end else if (start_ok) begin
            timeout_nxt = 1'b0;
            state_nxt   = ctrl_ext_sync_en ? S_ARM : S_PULSE;
        end else begin
            case (state)
                S_PULSE: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state_nxt = S_SETTLE;
                    end else begin
                        pulse_cnt_nxt = pulse_cnt + 1'b1;
                    end
                end
                S_ARM: begin
                    state_nxt  = S_WAIT_ARMED;
                    to_cnt_nxt = '0;
                end
                S_WAIT_ARMED, S_WAIT_TRIG: begin
                    if (!(&to_cnt)) begin
                        to_cnt_nxt = to_inc;
                    end
                    if ((state == S_WAIT_ARMED) && sync_armed) begin
                        state_nxt = S_WAIT_TRIG;
                    end else if ((state == S_WAIT_TRIG) && !sync_armed) begin
                        state_nxt = S_SETTLE;
                    end else if (to_hit) begin
                        state_nxt   = S_ERROR;
                        disarm_nxt  = 1'b1;
                        timeout_nxt = 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (link_ready) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state_nxt = S_RUNNING;
                            if (!(&status_sync_count)) begin
                                sync_count_nxt = status_sync_count + 1'b1;
                            end
                        end else begin
                            settle_cnt_nxt = settle_cnt + 1'b1;
                        end
                    end
                end
                S_RUNNING: begin
                    if (!link_ready) begin
                        state_nxt = S_SETTLE;
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= S_IDLE;
            pulse_cnt           <= '0;
            settle_cnt          <= '0;
            to_cnt              <= '0;
            dac_sync            <= 1'b0;
            dac_ext_sync_arm    <= 1'b0;
            dac_ext_sync_disarm <= 1'b0;
            status_busy         <= 1'b0;
            status_running      <= 1'b0;
            status_timeout      <= 1'b0;
            status_sync_count   <= '0;
        end else begin
            state               <= state_nxt;
            pulse_cnt           <= pulse_cnt_nxt;
            settle_cnt          <= settle_cnt_nxt;
            to_cnt              <= to_cnt_nxt;
            dac_sync            <= (state_nxt == S_PULSE);
            dac_ext_sync_arm    <= (state_nxt == S_ARM);
            dac_ext_sync_disarm <= disarm_nxt;
            status_busy         <= (state_nxt != S_IDLE) && (state_nxt != S_RUNNING) &&
                                   (state_nxt != S_ERROR);
            status_running      <= (state_nxt == S_RUNNING);
            status_timeout      <= timeout_nxt;
            status_sync_count   <= sync_count_nxt;
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Directed bench for the TPL DAC sync sequencer; expectations are cycle indices counted from the start edge.
module tb_ad_ip_jesd204_tpl_dac_sync_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_start, ctrl_abort, ctrl_ext_sync_en;
    logic [15:0] ctrl_timeout;
    logic        sync_armed, link_ready;
    logic        dac_sync, dac_ext_sync_arm, dac_ext_sync_disarm;
    logic        status_busy, status_running, status_timeout;
    logic [7:0]  status_sync_count;

    int n_chk  = 0;
    int n_pass = 0;
    int k, n_sync, n_arm, n_disarm, first_run, first_err, first_disarm;

    ad_ip_jesd204_tpl_dac_sync_ctrl #(
        .SYNC_PULSE_WIDTH(4),
        .SETTLE_CYCLES(16),
        .TIMEOUT_WIDTH(16),
        .CNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ctrl_start(ctrl_start),
        .ctrl_abort(ctrl_abort),
        .ctrl_ext_sync_en(ctrl_ext_sync_en),
        .ctrl_timeout(ctrl_timeout),
        .sync_armed(sync_armed),
        .link_ready(link_ready),
        .dac_sync(dac_sync),
        .dac_ext_sync_arm(dac_ext_sync_arm),
        .dac_ext_sync_disarm(dac_ext_sync_disarm),
        .status_busy(status_busy),
        .status_running(status_running),
        .status_timeout(status_timeout),
        .status_sync_count(status_sync_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic observe();
        if (dac_sync) n_sync++;
        if (dac_ext_sync_arm) n_arm++;
        if (dac_ext_sync_disarm) begin
            n_disarm++;
            if (first_disarm < 0) first_disarm = k;
        end
        if (status_running && first_run < 0) first_run = k;
        if (status_timeout && first_err < 0) first_err = k;
        k++;
    endtask

    // Start edge produces index 0.
    task automatic start_seq(input logic ext);
        ctrl_ext_sync_en = ext;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        k = 0; n_sync = 0; n_arm = 0; n_disarm = 0;
        first_run = -1; first_err = -1; first_disarm = -1;
        observe();
    endtask

    task automatic watch(input int n);
        repeat (n) begin
            tick();
            observe();
        end
    endtask

    initial begin
        reset = 1'b1;
        ctrl_start = 1'b0; ctrl_abort = 1'b0; ctrl_ext_sync_en = 1'b0;
        ctrl_timeout = 16'd100; sync_armed = 1'b0; link_ready = 1'b1;
        #1;
        chk("rst_outputs", {dac_sync, dac_ext_sync_arm, dac_ext_sync_disarm,
                            status_busy, status_running, status_timeout}, 0);
        chk("rst_count", status_sync_count, 0);
        #13 reset = 1'b0;
        tick();

        // Internal sync from IDLE.
        start_seq(1'b0);
        chk("int_sync_first", dac_sync, 1);
        chk("int_busy", status_busy, 1);
        watch(24);
        chk("int_sync_width", n_sync, 4);
        chk("int_no_arm", n_arm, 0);
        chk("int_run_idx", first_run, 20);
        chk("int_count", status_sync_count, 1);

        // External sync, trigger consumed well inside the timeout.
        start_seq(1'b1);
        chk("ext_run_drop", status_running, 0);
        chk("ext_arm_now", dac_ext_sync_arm, 1);
        while (k < 45) begin
            sync_armed = (k >= 4 && k < 24);
            tick();
            observe();
        end
        sync_armed = 1'b0;
        chk("ext_arm_cnt", n_arm, 1);
        chk("ext_no_sync", n_sync, 0);
        chk("ext_no_disarm", n_disarm, 0);
        chk("ext_run_idx", first_run, 40);
        chk("ext_no_timeout", status_timeout, 0);
        chk("ext_count", status_sync_count, 2);

        // External sync, sync_armed never rises.
        ctrl_timeout = 16'd50;
        start_seq(1'b1);
        watch(59);
        chk("to_err_idx", first_err, 51);
        chk("to_disarm_idx", first_disarm, 51);
        chk("to_disarm_cnt", n_disarm, 1);
        chk("to_flag", status_timeout, 1);
        chk("to_not_busy", status_busy, 0);
        chk("to_count_kept", status_sync_count, 2);
        start_seq(1'b0);
        chk("to_flag_clear", status_timeout, 0);
        watch(20);
        chk("to_recover_count", status_sync_count, 3);

        // Link flap at settle count 15.
        start_seq(1'b0);
        while (k < 40) begin
            link_ready = (k != 20);
            tick();
            observe();
        end
        link_ready = 1'b1;
        chk("flap_run_idx", first_run, 36);
        chk("flap_count", status_sync_count, 4);
        link_ready = 1'b0;
        tick();
        link_ready = 1'b1;
        chk("loss_running", status_running, 0);
        chk("loss_busy", status_busy, 1);
        chk("loss_count", status_sync_count, 4);
        repeat (15) tick();
        chk("loss_still_settle", status_running, 0);
        tick();
        chk("loss_rerun", status_running, 1);
        chk("loss_count_inc", status_sync_count, 5);

        // Abort in WAIT_TRIG.
        ctrl_timeout = 16'd100;
        start_seq(1'b1);
        sync_armed = 1'b1;
        watch(4);
        ctrl_abort = 1'b1;
        tick();
        ctrl_abort = 1'b0;
        chk("abort_disarm", dac_ext_sync_disarm, 1);
        chk("abort_idle", status_busy, 0);
        tick();
        sync_armed = 1'b0;
        chk("abort_disarm_1cyc", dac_ext_sync_disarm, 0);

        // Start and abort together from RUNNING.
        start_seq(1'b0);
        watch(20);
        chk("sa_running", status_running, 1);
        ctrl_start = 1'b1; ctrl_abort = 1'b1; ctrl_ext_sync_en = 1'b1;
        tick();
        ctrl_start = 1'b0; ctrl_abort = 1'b0;
        chk("sa_outputs", {dac_sync, dac_ext_sync_arm, dac_ext_sync_disarm,
                           status_busy, status_running}, 0);
        tick();
        chk("sa_stays_idle", {dac_sync, dac_ext_sync_arm, status_busy}, 0);
        chk("sa_count", status_sync_count, 6);
        ctrl_abort = 1'b1;
        tick();
        ctrl_abort = 1'b0;
        chk("idle_abort_noop", {dac_ext_sync_disarm, status_busy}, 0);

        // Reset during the second dac_sync cycle.
        start_seq(1'b0);
        tick();
        chk("rst_mid_sync_on", dac_sync, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_outputs", {dac_sync, dac_ext_sync_arm, dac_ext_sync_disarm,
                                status_busy, status_running, status_timeout}, 0);
        chk("rst_mid_count", status_sync_count, 0);
        #3 reset = 1'b0;
        tick();

        // Saturation of the sync counter.
        for (int i = 0; i < 300; i++) begin
            start_seq(1'b0);
            watch(20);
            if (i == 254) chk("sat_255", status_sync_count, 255);
        end
        chk("sat_hold", status_sync_count, 255);
        chk("sat_running", status_running, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_sync_ctrl.md
Name: ad_ip_jesd204_tpl_dac_sync_ctrl

Overview:
- Sequencer that starts and restarts the JESD204 DAC transport-layer datapath in a controlled way.
- Issues the software sync pulse, or arms/disarms the external sync and waits for the trigger, then waits for a stable link before declaring the datapath running.
- Sits between the register map and the TPL DAC core's dac_sync / dac_ext_sync_arm / dac_ext_sync_disarm inputs.
- Monitors the core's sync-armed status and link_ready.

Parameters:
SYNC_PULSE_WIDTH, 4, cycles dac_sync is held high in internal-sync mode (>=1)
SETTLE_CYCLES, 16, consecutive link_ready-high cycles required before RUNNING (>=1)
TIMEOUT_WIDTH, 16, width of the timeout counter and ctrl_timeout
CNT_WIDTH, 8, width of the successful-sync counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ctrl_start  in  1  single-cycle request to (re)start the sequence
ctrl_abort  in  1  single-cycle request to abandon the sequence and return to IDLE
ctrl_ext_sync_en  in  1  1 = external sync mode, 0 = internal (software) sync; sampled with ctrl_start
ctrl_timeout  in  TIMEOUT_WIDTH  wait limit in cycles for external-sync states; 0 disables the timeout
sync_armed  in  1  armed status from the core's external sync logic
link_ready  in  1  link ready from the JESD link layer
dac_sync  out  1  software sync/reset to the datapath
dac_ext_sync_arm  out  1  one-cycle arm pulse
dac_ext_sync_disarm  out  1  one-cycle disarm pulse
status_busy  out  1  high in any state other than IDLE, RUNNING, ERROR
status_running  out  1  high in RUNNING
status_timeout  out  1  sticky timeout flag
status_sync_count  out  CNT_WIDTH  number of entries into RUNNING, saturating

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0. Every output is registered.
- States: IDLE, PULSE, ARM, WAIT_ARMED, WAIT_TRIG, SETTLE, RUNNING, ERROR.
- Start acceptance:
  - ctrl_start is accepted in IDLE, RUNNING and ERROR; it is ignored in the other states.
  - Accepting it clears status_timeout and latches ctrl_ext_sync_en.
  - Next state is ARM if ext mode, else PULSE.
- Start sampled at edge N:
  - Internal mode: dac_sync is high for cycles N+1 .. N+SYNC_PULSE_WIDTH; the state then moves to SETTLE.
  - External mode: dac_ext_sync_arm is high for cycle N+1 only (ARM lasts 1 cycle); the state then moves to WAIT_ARMED.
- WAIT_ARMED: wait for sync_armed=1, then go to WAIT_TRIG. WAIT_TRIG: wait for sync_armed=0 (trigger consumed), then go to SETTLE. dac_sync stays 0 in both states, because the core ORs armed into its own sync.
- Timeout:
  - A single counter clears on entry to WAIT_ARMED and is not cleared on the WAIT_ARMED to WAIT_TRIG transition.
  - It increments each cycle in WAIT_ARMED and WAIT_TRIG.
  - When it equals ctrl_timeout (nonzero), the state goes to ERROR: dac_ext_sync_disarm is pulsed for 1 cycle and status_timeout is set.
  - With ctrl_timeout=0 the waits are unbounded and the counter saturates.
- SETTLE: a counter increments while link_ready=1 and clears to 0 whenever link_ready=0. On reaching SETTLE_CYCLES the state moves to RUNNING, and status_sync_count increments, saturating at all-ones.
- RUNNING: if link_ready drops, the state returns to SETTLE; the count does not increment again until RUNNING is re-entered.
- Abort:
  - In any state except IDLE, ctrl_abort moves the state to IDLE next cycle and forces dac_sync low.
  - From WAIT_ARMED or WAIT_TRIG, abort also pulses dac_ext_sync_disarm for 1 cycle.
  - Abort in IDLE is a no-op.
- Simultaneous ctrl_start and ctrl_abort: abort wins and start is dropped.
- ctrl_start in RUNNING re-sequences without passing through IDLE; status_running drops at the next edge.
- Reset asserted mid-sequence: all outputs drop to 0 asynchronously, including an in-progress dac_sync pulse. status_sync_count is cleared.

Test Plan:
- Internal sync, SYNC_PULSE_WIDTH=4, SETTLE_CYCLES=16, link_ready=1, start at edge 10 -> dac_sync high cycles 11-14; status_running rises at cycle 31±1 per state encoding; status_sync_count=1.
- External sync, ctrl_timeout=100: start, sync_armed rises 3 cycles after the arm pulse and falls 20 cycles later -> arm high exactly 1 cycle, dac_sync never high, SETTLE then RUNNING, no timeout.
- External sync, ctrl_timeout=50, sync_armed never rises -> ERROR 50 cycles after entering WAIT_ARMED, one disarm pulse, status_timeout=1; next start clears the flag.
- Link flaps: link_ready low for 1 cycle at SETTLE count 15 -> settle restarts from 0 and RUNNING is delayed 16 more cycles; later link loss in RUNNING returns to SETTLE, count unchanged until re-entry.
- Abort during WAIT_TRIG, plus start and abort in the same cycle from RUNNING -> disarm pulse and IDLE; in the second case IDLE with no arm or sync pulse.
- Reset asserted during dac_sync pulse cycle 2; separately, 300 successful syncs with CNT_WIDTH=8 -> all outputs 0 immediately on reset; status_sync_count saturates at 255.
